// File: rtl/conv_result_uart_tx_pkg.sv
// Shared types and constants for the DoG convolutor result path.
// Holds the UART FSM state type and the baud divisor helper.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int DOG_KERNEL_DIM = 7;
  localparam int DOG_BORDER     = 6;

  // Rounded divisor so the bit period error stays within half a clock.
  function automatic int clks_per_bit(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud / 2) / baud);
  endfunction

endpackage

// File: rtl/conv_result_uart_tx_if.sv
// Filtered pixel stream from the convolutor: one-cycle valid strobe plus data.
interface conv_result_uart_tx_if #(
  parameter int D_BITS = 8
);
  logic              dvalid;
  logic [D_BITS-1:0] data;

  modport master (output dvalid, output data);
  modport slave  (input  dvalid, input  data);
endinterface

// File: rtl/conv_result_uart_tx_sync_fifo.sv
// Synchronous FIFO with registered read data (dout valid the cycle after pop).
// A push while full is only taken when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    // Reads old contents, so a full-FIFO push/pop on the same slot is safe.
    if (pop_ok) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/conv_result_uart_tx.sv
// Buffers convolutor output pixels and streams them to the host as UART 8N1,
// counting pixels per frame and flagging frame completion and drops.
module conv_result_uart_tx
  import conv_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int D_BITS       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 1
) (
  input  logic                          i_clk,
  input  logic                          reset,
  conv_result_uart_tx_if.slave          pix,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow,
  output logic                          o_frame_done
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int BCW = $clog2(CPB);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PCW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  uart_state_t       state_q, state_d;
  logic [BCW-1:0]    bc_q, bc_d;
  logic [2:0]        bi_q, bi_d;
  logic [7:0]        sh_q, sh_d;
  logic              load_q, load_d;
  logic              tx_q, tx_d;
  logic [PCW-1:0]    pix_q, pix_d;
  logic              ovf_q, ovf_d;

  logic              pop, bit_end, stop_end;
  logic [D_BITS-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (D_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .reset (reset),
    .push  (pix.dvalid),
    .pop   (pop),
    .din   (pix.data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end  = (bc_q == BCW'(CPB - 1));
  assign stop_end = (state_q == STOP) && bit_end;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bc_q    <= '0;
      bi_q    <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      bi_q    <= bi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q + BCW'(1);
    bi_d    = bi_q;
    case (state_q)
      IDLE: begin
        bc_d = '0;
        if (!fifo_empty) state_d = START;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bc_d    = '0;
        bi_d    = '0;
      end
      DATA: if (bit_end) begin
        bc_d = '0;
        if (bi_q == 3'd7) state_d = STOP;
        else              bi_d    = bi_q + 3'd1;
      end
      STOP: if (bit_end) begin
        bc_d    = '0;
        state_d = fifo_empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the upcoming state so the line tracks state_q exactly.
  always_comb begin
    pop          = ((state_q == IDLE) || stop_end) && !fifo_empty;
    o_frame_done = stop_end && (pix_q == PCW'(FRAME_PIXELS - 1));
    o_busy       = (state_q != IDLE) || (fifo_count != '0);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_q[bi_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    load_d = pop;
    sh_d   = load_q ? fifo_dout : sh_q;
    ovf_d  = ovf_q | (pix.dvalid & fifo_full & ~pop);
    pix_d  = pix_q;
    if (stop_end) pix_d = o_frame_done ? '0 : pix_q + PCW'(1);
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '0;
      load_q <= 1'b0;
      tx_q   <= 1'b1;
      pix_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      load_q <= load_d;
      tx_q   <= tx_d;
      pix_q  <= pix_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_tx         = tx_q;
  assign o_fifo_count = fifo_count;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_conv_result_uart_tx.sv
// Bench for conv_result_uart_tx: two instances (16-deep/1-pixel frames and
// 4-deep/4-pixel frames) driven with random bytes and decoded off the UART line.
module tb_conv_result_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  conv_result_uart_tx_if #(.D_BITS(8)) if_a ();
  conv_result_uart_tx_if #(.D_BITS(8)) if_b ();

  logic       tx_a, busy_a, ovf_a, fd_a;
  logic [4:0] cnt_a;
  logic       tx_b, busy_b, ovf_b, fd_b;
  logic [2:0] cnt_b;

  conv_result_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .D_BITS(8),
                        .FIFO_DEPTH(16), .FRAME_PIXELS(1)) dut_a (
    .i_clk(clk), .reset(rst), .pix(if_a), .o_tx(tx_a), .o_busy(busy_a),
    .o_fifo_count(cnt_a), .o_overflow(ovf_a), .o_frame_done(fd_a));

  conv_result_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .D_BITS(8),
                        .FIFO_DEPTH(4), .FRAME_PIXELS(4)) dut_b (
    .i_clk(clk), .reset(rst), .pix(if_b), .o_tx(tx_b), .o_busy(busy_b),
    .o_fifo_count(cnt_b), .o_overflow(ovf_b), .o_frame_done(fd_b));

  // UART line decoders: sample mid-slot, record byte, start cycle, framing, done pulses.
  logic [7:0] rx_a[$], rx_b[$];
  int         st_a[$], st_b[$], fdc_a[$], fdc_b[$];
  bit         ok_a[$], ok_b[$];
  bit         ma_act = 0, mb_act = 0;
  int         ma_pos = 0, mb_pos = 0;
  logic [9:0] ma_sh = '0, mb_sh = '0;

  always @(negedge clk) begin
    if (rst) ma_act <= 0;
    else begin
      if (fd_a) fdc_a.push_back(cyc);
      if (!ma_act && tx_a == 1'b0) begin
        ma_act <= 1; ma_pos <= 1; st_a.push_back(cyc);
      end else if (ma_act) begin
        ma_pos <= ma_pos + 1;
        if (ma_pos % CPB == CPB / 2) begin
          ma_sh <= {tx_a, ma_sh[9:1]};
          if (ma_pos == 9 * CPB + CPB / 2) begin
            rx_a.push_back(ma_sh[9:2]);
            ok_a.push_back(ma_sh[1] == 1'b0 && tx_a == 1'b1);
            ma_act <= 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) mb_act <= 0;
    else begin
      if (fd_b) fdc_b.push_back(cyc);
      if (!mb_act && tx_b == 1'b0) begin
        mb_act <= 1; mb_pos <= 1; st_b.push_back(cyc);
      end else if (mb_act) begin
        mb_pos <= mb_pos + 1;
        if (mb_pos % CPB == CPB / 2) begin
          mb_sh <= {tx_b, mb_sh[9:1]};
          if (mb_pos == 9 * CPB + CPB / 2) begin
            rx_b.push_back(mb_sh[9:2]);
            ok_b.push_back(mb_sh[1] == 1'b0 && tx_b == 1'b1);
            mb_act <= 0;
          end
        end
      end
    end
  end

  task automatic clear_q();
    rx_a.delete(); st_a.delete(); ok_a.delete(); fdc_a.delete();
    rx_b.delete(); st_b.delete(); ok_b.delete(); fdc_b.delete();
  endtask

  task automatic at_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1 clear_q();
  endtask

  task automatic wait_rx(input bit sel_b, input int n, input int limit);
    int w = 0;
    while (((sel_b ? rx_b.size() : rx_a.size()) < n) && w < limit) begin
      @(negedge clk); w++;
    end
    vectors++;
    if ((sel_b ? rx_b.size() : rx_a.size()) < n) begin
      miscompares++;
      $display("FAIL wait_rx(%0d): got %0d frames, want %0d", sel_b,
               sel_b ? rx_b.size() : rx_a.size(), n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; if_a.dvalid = 0; if_b.dvalid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    clear_q();
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors += 10;
    if (tx_a !== 1'b1)   begin miscompares++; $display("FAIL rst_tx_a: got %b want 1", tx_a); end
    if (busy_a !== 1'b0) begin miscompares++; $display("FAIL rst_busy_a: got %b want 0", busy_a); end
    if (cnt_a !== 5'd0)  begin miscompares++; $display("FAIL rst_cnt_a: got %0d want 0", cnt_a); end
    if (ovf_a !== 1'b0)  begin miscompares++; $display("FAIL rst_ovf_a: got %b want 0", ovf_a); end
    if (fd_a !== 1'b0)   begin miscompares++; $display("FAIL rst_fd_a: got %b want 0", fd_a); end
    if (tx_b !== 1'b1)   begin miscompares++; $display("FAIL rst_tx_b: got %b want 1", tx_b); end
    if (busy_b !== 1'b0) begin miscompares++; $display("FAIL rst_busy_b: got %b want 0", busy_b); end
    if (cnt_b !== 3'd0)  begin miscompares++; $display("FAIL rst_cnt_b: got %0d want 0", cnt_b); end
    if (ovf_b !== 1'b0)  begin miscompares++; $display("FAIL rst_ovf_b: got %b want 0", ovf_b); end
    if (fd_b !== 1'b0)   begin miscompares++; $display("FAIL rst_fd_b: got %b want 0", fd_b); end
    #1 rst = 0;
  endtask

  task automatic test_single();
    int t0;
    logic [9:0] frame;
    settle();
    frame = {1'b1, 8'hA5, 1'b0};
    @(posedge clk); #1; t0 = cyc; if_a.dvalid = 1; if_a.data = 8'hA5;
    @(posedge clk); #1; if_a.dvalid = 0;
    @(negedge clk);
    vectors += 2;
    if (cnt_a !== 5'd1) begin miscompares++; $display("FAIL single_cnt: got %0d want 1", cnt_a); end
    if (tx_a !== 1'b1)  begin miscompares++; $display("FAIL single_tx_n1: got %b want 1", tx_a); end
    at_cycle(t0 + 2);
    vectors++;
    if (tx_a !== 1'b0) begin miscompares++; $display("FAIL single_tx_fall: got %b want 0", tx_a); end
    for (int k = 0; k < 10; k++) begin
      at_cycle(t0 + 2 + k * CPB + CPB / 2);
      vectors++;
      if (tx_a !== frame[k]) begin miscompares++; $display("FAIL single_bit%0d: got %b want %b", k, tx_a, frame[k]); end
    end
    at_cycle(t0 + 100);
    vectors++;
    if (fd_a !== 1'b0) begin miscompares++; $display("FAIL single_fd_early: got %b want 0", fd_a); end
    at_cycle(t0 + 101);
    vectors += 2;
    if (fd_a !== 1'b1)   begin miscompares++; $display("FAIL single_fd: got %b want 1", fd_a); end
    if (busy_a !== 1'b1) begin miscompares++; $display("FAIL single_busy101: got %b want 1", busy_a); end
    at_cycle(t0 + 102);
    vectors += 3;
    if (fd_a !== 1'b0)   begin miscompares++; $display("FAIL single_fd_after: got %b want 0", fd_a); end
    if (busy_a !== 1'b0) begin miscompares++; $display("FAIL single_busy102: got %b want 0", busy_a); end
    if (rx_a.size() != 1 || rx_a[0] !== 8'hA5 || !ok_a[0]) begin
      miscompares++; $display("FAIL single_rx: got %0d frames, want one 0xa5", rx_a.size());
    end
  endtask

  task automatic test_burst();
    logic [7:0] b[3];
    int t0 = 0, peak = 0;
    settle();
    b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      if_a.dvalid = 1; if_a.data = b[i];
      @(negedge clk); if (int'(cnt_a) > peak) peak = int'(cnt_a);
    end
    @(posedge clk); #1 if_a.dvalid = 0;
    repeat (4) begin @(negedge clk); if (int'(cnt_a) > peak) peak = int'(cnt_a); end
    vectors++;
    if (peak != 2) begin miscompares++; $display("FAIL burst_peak: got %0d want 2", peak); end
    wait_rx(0, 3, 500);
    if (rx_a.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rx_a[i] !== b[i] || !ok_a[i]) begin miscompares++; $display("FAIL burst_byte%0d: got %h want %h", i, rx_a[i], b[i]); end
      end
      vectors += 3;
      if (st_a[0] != t0 + 2)   begin miscompares++; $display("FAIL burst_start: got %0d want %0d", st_a[0], t0 + 2); end
      if (st_a[1] - st_a[0] != 10 * CPB) begin miscompares++; $display("FAIL burst_gap1: got %0d want %0d", st_a[1] - st_a[0], 10 * CPB); end
      if (st_a[2] - st_a[1] != 10 * CPB) begin miscompares++; $display("FAIL burst_gap2: got %0d want %0d", st_a[2] - st_a[1], 10 * CPB); end
    end
  endtask

  task automatic test_reset_midbyte();
    int t0;
    settle();
    @(posedge clk); #1; t0 = cyc; if_a.dvalid = 1; if_a.data = 8'hC3;
    @(posedge clk); #1; if_a.dvalid = 0;
    at_cycle(t0 + 36);
    vectors++;
    if (tx_a !== 1'b0) begin miscompares++; $display("FAIL mid_tx_before: got %b want 0", tx_a); end
    @(posedge clk); #1; rst = 1;
    #1;
    vectors += 4;
    if (tx_a !== 1'b1)   begin miscompares++; $display("FAIL mid_tx_rst: got %b want 1", tx_a); end
    if (cnt_a !== 5'd0)  begin miscompares++; $display("FAIL mid_cnt_rst: got %0d want 0", cnt_a); end
    if (ovf_a !== 1'b0)  begin miscompares++; $display("FAIL mid_ovf_rst: got %b want 0", ovf_a); end
    if (busy_a !== 1'b0) begin miscompares++; $display("FAIL mid_busy_rst: got %b want 0", busy_a); end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    settle();
    @(posedge clk); #1; if_a.dvalid = 1; if_a.data = 8'h81;
    @(posedge clk); #1; if_a.dvalid = 0;
    wait_rx(0, 1, 200);
    vectors++;
    if (rx_a.size() < 1 || rx_a[0] !== 8'h81 || !ok_a[0]) begin
      miscompares++; $display("FAIL mid_after: got %h want 81", rx_a.size() ? rx_a[0] : 8'hxx);
    end
  endtask

  // Reference: a byte accepted at cycle t is popped at max(t+1, previous pop + 10*CPB);
  // it occupies the FIFO from t+1 through its pop cycle.
  task automatic test_random_a();
    localparam int N = 24;
    int pt[N];
    logic [7:0] pv[N];
    int pa[$], pp[$];
    logic [7:0] ex[$];
    bit exp_ovf = 0;
    int t0 = 0, k = 0;
    settle();
    pt[0] = 0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) pt[i] = pt[i-1] + 1 + int'($urandom_range(0, 12));
      pv[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < N; i++) begin
      int occ = 0, p, prev;
      bit popnow = 0;
      foreach (pa[j]) if (pa[j] < pt[i]) occ++;
      foreach (pp[j]) begin
        if (pp[j] < pt[i]) occ--;
        if (pp[j] == pt[i]) popnow = 1;
      end
      if (occ < 16 || popnow) begin
        prev = (pp.size() > 0) ? pp[pp.size()-1] : -100000;
        p = (pt[i] + 1 > prev + 10 * CPB) ? pt[i] + 1 : prev + 10 * CPB;
        pa.push_back(pt[i]); pp.push_back(p); ex.push_back(pv[i]);
      end else exp_ovf = 1;
    end
    for (int c = 0; c <= pt[N-1]; c++) begin
      @(posedge clk); #1;
      if (c == 0) t0 = cyc;
      if (k < N && pt[k] == c) begin
        if_a.dvalid = 1; if_a.data = pv[k]; k++;
      end else if_a.dvalid = 0;
    end
    @(posedge clk); #1 if_a.dvalid = 0;
    wait_rx(0, ex.size(), ex.size() * 10 * CPB + 300);
    repeat (20) @(negedge clk);
    vectors += 2;
    if (rx_a.size() != ex.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", rx_a.size(), ex.size()); end
    if (ovf_a !== exp_ovf) begin miscompares++; $display("FAIL rand_ovf: got %b want %b", ovf_a, exp_ovf); end
    for (int i = 0; i < ex.size() && i < rx_a.size(); i++) begin
      vectors += 2;
      if (rx_a[i] !== ex[i] || !ok_a[i]) begin miscompares++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_a[i], ex[i]); end
      if (st_a[i] != t0 + pp[i] + 1) begin miscompares++; $display("FAIL rand_start%0d: got %0d want %0d", i, st_a[i] - t0, pp[i] + 1); end
    end
  endtask

  task automatic test_overflow_b();
    logic [7:0] v[6];
    int t0 = 0;
    settle();
    for (int i = 0; i < 6; i++) v[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      if_b.dvalid = 1; if_b.data = v[i];
    end
    @(negedge clk);
    vectors += 2;
    if (cnt_b !== 3'd4) begin miscompares++; $display("FAIL ovf_cnt5: got %0d want 4", cnt_b); end
    if (ovf_b !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", ovf_b); end
    @(posedge clk); #1 if_b.dvalid = 0;
    @(negedge clk);
    vectors += 2;
    if (cnt_b !== 3'd4) begin miscompares++; $display("FAIL ovf_cnt6: got %0d want 4", cnt_b); end
    if (ovf_b !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", ovf_b); end
    wait_rx(1, 5, 700);
    repeat (20) @(negedge clk);
    vectors += 3;
    if (rx_b.size() != 5) begin miscompares++; $display("FAIL ovf_frames: got %0d want 5", rx_b.size()); end
    if (ovf_b !== 1'b1)   begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", ovf_b); end
    if (fdc_b.size() != 1) begin miscompares++; $display("FAIL ovf_fd_count: got %0d want 1", fdc_b.size()); end
    for (int i = 0; i < 5 && i < rx_b.size(); i++) begin
      vectors++;
      if (rx_b[i] !== v[i] || !ok_b[i]) begin miscompares++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_b[i], v[i]); end
    end
  endtask

  task automatic test_full_push_pop_b();
    logic [7:0] v[6];
    int t0 = 0;
    do_reset();
    settle();
    for (int i = 0; i < 6; i++) v[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      if_b.dvalid = 1; if_b.data = v[i];
    end
    @(posedge clk); #1 if_b.dvalid = 0;
    at_cycle(t0 + 100);
    vectors++;
    if (cnt_b !== 3'd4) begin miscompares++; $display("FAIL fpp_full: got %0d want 4", cnt_b); end
    @(posedge clk); #1; if_b.dvalid = 1; if_b.data = v[5];
    @(posedge clk); #1; if_b.dvalid = 0;
    @(negedge clk);
    vectors += 2;
    if (cnt_b !== 3'd4) begin miscompares++; $display("FAIL fpp_cnt: got %0d want 4", cnt_b); end
    if (ovf_b !== 1'b0) begin miscompares++; $display("FAIL fpp_ovf: got %b want 0", ovf_b); end
    wait_rx(1, 6, 800);
    for (int i = 0; i < 6 && i < rx_b.size(); i++) begin
      vectors++;
      if (rx_b[i] !== v[i] || !ok_b[i]) begin miscompares++; $display("FAIL fpp_byte%0d: got %h want %h", i, rx_b[i], v[i]); end
    end
  endtask

  task automatic test_frame_done_b();
    logic [7:0] v[8];
    do_reset();
    settle();
    for (int i = 0; i < 8; i++) begin
      v[i] = 8'($urandom_range(0, 255));
      repeat ($urandom_range(80, 150)) @(posedge clk);
      #1; if_b.dvalid = 1; if_b.data = v[i];
      @(posedge clk); #1 if_b.dvalid = 0;
    end
    wait_rx(1, 8, 1200);
    repeat (10) @(negedge clk);
    vectors++;
    if (fdc_b.size() != 2) begin miscompares++; $display("FAIL frame_pulses: got %0d want 2", fdc_b.size()); end
    if (fdc_b.size() == 2 && st_b.size() >= 8) begin
      vectors += 2;
      if (fdc_b[0] != st_b[3] + 10 * CPB - 1) begin miscompares++; $display("FAIL frame_fd0: got %0d want %0d", fdc_b[0], st_b[3] + 10 * CPB - 1); end
      if (fdc_b[1] != st_b[7] + 10 * CPB - 1) begin miscompares++; $display("FAIL frame_fd1: got %0d want %0d", fdc_b[1], st_b[7] + 10 * CPB - 1); end
    end
    for (int i = 0; i < 8 && i < rx_b.size(); i++) begin
      vectors++;
      if (rx_b[i] !== v[i] || !ok_b[i]) begin miscompares++; $display("FAIL frame_byte%0d: got %h want %h", i, rx_b[i], v[i]); end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.dvalid = 0; if_a.data = '0;
    if_b.dvalid = 0; if_b.data = '0;
    test_reset();
    test_single();
    test_burst();
    test_reset_midbyte();
    test_random_a();
    test_overflow_b();
    test_full_push_pop_b();
    test_frame_done_b();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
